// File: rtl/ptp_pkg.sv
// Shared PTP definitions: timestamp entry width and the queue status word layout.
package ptp_pkg;

  localparam int PTP_TS_ENTRY_W = 128;

  localparam int STAT_OVF     = 7;
  localparam int STAT_FULL    = 6;
  localparam int STAT_EMPTY   = 5;
  localparam int STAT_CNT_LSB = 0;

  localparam logic [7:0] STAT_RESET = 8'h20;

  // Builds the status byte from its fields; count is zero-extended to 5 bits.
  function automatic logic [7:0] pack_stat(input logic ovf, input logic full,
                                           input logic empty, input logic [4:0] cnt);
    logic [7:0] s;
    s = '0;
    s[STAT_OVF]   = ovf;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_CNT_LSB +: 5] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/ptp_ts_queue_ram.sv
// Simple dual-port timestamp RAM; the read register is the pop output register.
module ptp_ts_queue_ram
  import ptp_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = PTP_TS_ENTRY_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first: a same-edge write to rd_addr returns the old (oldest) entry.
  always_ff @(posedge clk) begin
    if (rd_clr)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ptp_ts_queue.sv
// Timestamp queue between the TSU capture stage and the PTP register block.
module ptp_ts_queue
  import ptp_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = PTP_TS_ENTRY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_rst,
  input  logic              q_wr_en,
  input  logic [3:0]        q_wr_msgid,
  input  logic [DATA_W-1:0] q_wr_data,
  input  logic [7:0]        q_msgid_mask,
  input  logic              q_rd_en,
  output logic [DATA_W-1:0] q_data_out,
  output logic [7:0]        q_stat_out
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(1) << ADDR_W;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_nxt;
  logic              ovf, ovf_nxt;
  logic [7:0]        stat_q;
  logic [4:0]        cnt5;
  logic              flush, accept, empty, full, do_wr, do_pop;

  assign flush  = rst | q_rst;
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign accept = q_wr_en & ~q_wr_msgid[3] & q_msgid_mask[q_wr_msgid[2:0]];
  assign do_pop = q_rd_en & ~empty;
  assign do_wr  = accept & (~full | q_rd_en);

  always_comb begin
    count_nxt = count;
    ovf_nxt   = ovf | (accept & full & ~q_rd_en);
    cnt5      = '0;
    if (do_wr & ~do_pop)      count_nxt = count + 1'b1;
    else if (do_pop & ~do_wr) count_nxt = count - 1'b1;
    cnt5[ADDR_W:0] = count_nxt;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      stat_q <= STAT_RESET;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      count  <= count_nxt;
      ovf    <= ovf_nxt;
      stat_q <= pack_stat(ovf_nxt, count_nxt == FULL_CNT, count_nxt == '0, cnt5);
    end
  end

  // A pop on an empty queue clears the output rather than holding it.
  ptp_ts_queue_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .wr_en   (do_wr & ~flush),
    .wr_addr (wr_ptr),
    .wr_data (q_wr_data),
    .rd_en   (do_pop & ~flush),
    .rd_clr  (flush | (q_rd_en & empty)),
    .rd_addr (rd_ptr),
    .rd_data (q_data_out)
  );

  assign q_stat_out = stat_q;

endmodule

// File: tb/tb_ptp_ts_queue.sv
// Self-checking bench for ptp_ts_queue against a queue-based reference model.
module tb_ptp_ts_queue;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst, q_rst, q_wr_en, q_rd_en;
  logic [3:0]   q_wr_msgid;
  logic [127:0] q_wr_data, q_data_out;
  logic [7:0]   q_msgid_mask, q_stat_out;

  logic [127:0] model_q[$];
  logic         model_ovf;
  logic [127:0] exp_data;
  logic [7:0]   exp_stat;
  int           vectors_applied = 0;
  int           miscompares = 0;

  ptp_ts_queue dut (
    .clk(clk), .rst(rst), .q_rst(q_rst), .q_wr_en(q_wr_en), .q_wr_msgid(q_wr_msgid),
    .q_wr_data(q_wr_data), .q_msgid_mask(q_msgid_mask), .q_rd_en(q_rd_en),
    .q_data_out(q_data_out), .q_stat_out(q_stat_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag);
    vectors_applied++;
    assert (q_data_out === exp_data) else begin
      miscompares++;
      $error("[TB] FAIL %s data: observed %h expected %h", tag, q_data_out, exp_data);
    end
    vectors_applied++;
    assert (q_stat_out === exp_stat) else begin
      miscompares++;
      $error("[TB] FAIL %s stat: observed %h expected %h", tag, q_stat_out, exp_stat);
    end
  endtask

  task automatic checkStat(input string tag, input logic [7:0] want);
    vectors_applied++;
    assert (q_stat_out === want) else begin
      miscompares++;
      $error("[TB] FAIL %s stat: observed %h expected %h", tag, q_stat_out, want);
    end
  endtask

  // One clock of stimulus; the model applies the queue rules, then both are compared.
  task automatic applyStimulus(input bit r, input bit qr, input bit wr, input logic [3:0] id,
                               input logic [127:0] d, input logic [7:0] m, input bit rd,
                               input string tag);
    int  pre_size;
    bit  acc;
    @(negedge clk);
    rst = r; q_rst = qr; q_wr_en = wr; q_wr_msgid = id; q_wr_data = d;
    q_msgid_mask = m; q_rd_en = rd;
    if (r || qr) begin
      model_q.delete();
      model_ovf = 1'b0;
      exp_data  = '0;
    end else begin
      pre_size = model_q.size();
      acc = wr && (id < 8) && m[id[2:0]];
      if (rd) exp_data = (pre_size > 0) ? model_q.pop_front() : '0;
      if (acc) begin
        if (pre_size < DEPTH || rd) model_q.push_back(d);
        else model_ovf = 1'b1;
      end
    end
    exp_stat = {model_ovf, model_q.size() == DEPTH, model_q.size() == 0, 5'(model_q.size())};
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [127:0] a5 = 128'hA5A5_A5A5_0000_1111_2222_3333_4444_5501;
    logic [127:0] rnd;
    model_ovf = 1'b0;
    exp_data  = '0;

    applyStimulus(1, 0, 0, 0, '0, 8'h00, 0, "reset");
    checkStat("reset_const", 8'h20);
    applyStimulus(0, 0, 1, 0, a5, 8'h01, 0, "single_wr");
    checkStat("single_wr_const", 8'h01);
    applyStimulus(0, 0, 0, 0, '0, 8'h01, 1, "single_pop");
    checkStat("single_pop_const", 8'h20);
    applyStimulus(0, 0, 0, 0, '0, 8'h01, 0, "hold");

    applyStimulus(0, 0, 1, 4'd0, 128'h10, 8'h02, 0, "mask_id0");
    applyStimulus(0, 0, 1, 4'd1, 128'h11, 8'h02, 0, "mask_id1");
    applyStimulus(0, 0, 1, 4'd3, 128'h13, 8'h02, 0, "mask_id3");
    applyStimulus(0, 0, 1, 4'd9, 128'h19, 8'h02, 0, "mask_id9");
    checkStat("mask_const", 8'h01);
    applyStimulus(0, 0, 1, 4'd8, 128'h18, 8'hFF, 0, "mask_id8");
    applyStimulus(0, 0, 0, 0, '0, 8'hFF, 1, "mask_pop");

    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 128'(i), 8'h01, 0, "fill");
    checkStat("full_const", 8'h50);
    applyStimulus(0, 0, 1, 0, 128'hDEAD, 8'h01, 0, "overflow");
    checkStat("ovf_const", 8'hD0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, '0, 8'h01, 1, "drain");
    checkStat("drained_const", 8'hA0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 128'h100 + 128'(i), 8'h01, 0, "refill");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, '0, 8'h01, 1, "wrap_pop");

    applyStimulus(0, 1, 0, 0, '0, 8'h01, 0, "flush_ovf");
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 128'h200 + 128'(i), 8'h01, 0, "fill2");
    applyStimulus(0, 0, 1, 0, 128'h2FF, 8'h01, 1, "full_wr_pop");
    checkStat("full_wr_pop_const", 8'h50);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, '0, 8'h01, 1, "drain2");
    applyStimulus(0, 0, 1, 0, 128'h300, 8'h01, 1, "empty_wr_pop");
    checkStat("empty_wr_pop_const", 8'h01);
    applyStimulus(0, 0, 0, 0, '0, 8'h01, 1, "pop_last");
    applyStimulus(0, 0, 0, 0, '0, 8'h01, 1, "empty_pop");
    checkStat("empty_pop_const", 8'h20);

    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 128'h400 + 128'(i), 8'h01, 0, "pre_flush");
    applyStimulus(0, 0, 0, 0, '0, 8'h01, 1, "pre_flush_pop");
    applyStimulus(0, 1, 1, 0, 128'h4FF, 8'h01, 1, "flush_mid");
    checkStat("flush_const", 8'h20);
    applyStimulus(0, 0, 1, 0, 128'h500, 8'h01, 0, "post_flush_wr");
    applyStimulus(0, 0, 0, 0, '0, 8'h01, 1, "post_flush_pop");

    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(0, ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75),
                    4'($urandom_range(0, 15)), rnd, 8'($urandom),
                    ($urandom_range(0, 99) < ((i < 300) ? 25 : 70)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule
